// File: rtl/dbg_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// dbg_run_ctrl_if
// Command channel between the debug command parser and the run-control
// sequencer.
//
//   cmd_vld  parser -> sequencer  command valid
//   cmd_rdy  sequencer -> parser  command ready (accept on vld & rdy)
//   cmd_op   parser -> sequencer  0=STEP 1=RUN 2=HALT 3=SETBP 4=CLRBP 5=CLRALL
//   cmd_idx  parser -> sequencer  breakpoint slot for SETBP/CLRBP
//   cmd_arg  parser -> sequencer  breakpoint address or step count
//   cmd_err  sequencer -> parser  one-cycle pulse when a command is rejected
//
// Modports: master (command parser), slave (run-control sequencer).
// ---------------------------------------------------------------------------
interface dbg_run_ctrl_if #(
  parameter int IDX_W = 2
);
  logic             cmd_vld;
  logic             cmd_rdy;
  logic [2:0]       cmd_op;
  logic [IDX_W-1:0] cmd_idx;
  logic [31:0]      cmd_arg;
  logic             cmd_err;

  modport master (
    output cmd_vld,
    output cmd_op,
    output cmd_idx,
    output cmd_arg,
    input  cmd_rdy,
    input  cmd_err
  );

  modport slave (
    input  cmd_vld,
    input  cmd_op,
    input  cmd_idx,
    input  cmd_arg,
    output cmd_rdy,
    output cmd_err
  );
endinterface

// File: rtl/dbg_run_ctrl.sv
// ---------------------------------------------------------------------------
// dbg_run_ctrl
// Run-control sequencer for the debug unit's CPU clock. Accepts one-shot
// commands (step, run, halt, breakpoint set/clear), produces the gated
// cpu_clk pulse train (1 clk high, 2 clk low per pulse) and compares the
// IF-stage PC against a small breakpoint file after every pulse. A single
// registered 'done' pulse marks every stop so the front end can dump state.
//
// Parameters:
//   BP_NUM  number of breakpoint slots (power of two, 1..16)
//   IDX_W   slot index width, clog2(BP_NUM), minimum 1
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   cmd         command channel (dbg_run_ctrl_if.slave)
//   pc          CPU IF-stage PC, advanced by cpu_clk rising edge
//   cpu_clk     gated CPU clock, registered
//   running     high while a STEP or RUN is in progress
//   done        one-cycle stop event
//   stop_cause  0=step count exhausted, 1=breakpoint, 2=halt
//   bp_hit_idx  matching breakpoint slot, valid when stop_cause=1
//   cyc_cnt     CPU pulses issued since the last STEP/RUN
//
// Build option:
//   DBG_CYC_CNT_EN  when defined, cyc_cnt counts P_HI cycles; otherwise it
//                   is tied to zero and the counter is not built.
// ---------------------------------------------------------------------------
module dbg_run_ctrl #(
  parameter int BP_NUM = 4,
  parameter int IDX_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  dbg_run_ctrl_if.slave    cmd,
  input  logic [31:0]      pc,
  output logic             cpu_clk,
  output logic             running,
  output logic             done,
  output logic [1:0]       stop_cause,
  output logic [IDX_W-1:0] bp_hit_idx,
  output logic [31:0]      cyc_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P_HI = 2'd1,
    P_LO = 2'd2,
    CHK  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OP_STEP   = 3'd0,
    OP_RUN    = 3'd1,
    OP_HALT   = 3'd2,
    OP_SETBP  = 3'd3,
    OP_CLRBP  = 3'd4,
    OP_CLRALL = 3'd5,
    OP_RSVD6  = 3'd6,
    OP_RSVD7  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    CAUSE_STEP = 2'd0,
    CAUSE_BP   = 2'd1,
    CAUSE_HALT = 2'd2
  } cause_e;

  state_e           state;
  state_e           next_state;
  op_e              op;
  cause_e           cause_q;
  cause_e           cause_nxt;

  logic             accept;
  logic             in_idle;
  logic             start;
  logic             is_halt;
  logic             is_rsvd;
  logic             bp_wr_ok;
  logic             idx_ok;
  logic             stop;
  logic             err_nxt;
  logic             cmd_err_q;

  logic             halt_pend;
  logic             step_mode;
  logic [15:0]      step_cnt;
  logic [15:0]      step_load;

  logic [BP_NUM-1:0] bp_en;
  logic [31:0]       bp_addr [BP_NUM];
  logic              bp_hit;
  logic [IDX_W-1:0]  bp_idx;

  // The sequencer never back-pressures; illegal commands are reported via
  // cmd_err instead.
  assign cmd.cmd_rdy = 1'b1;
  assign cmd.cmd_err = cmd_err_q;

  assign op        = op_e'(cmd.cmd_op);
  assign accept    = cmd.cmd_vld;
  assign in_idle   = (state == IDLE);
  assign is_halt   = (op == OP_HALT);
  assign is_rsvd   = (op == OP_RSVD6) || (op == OP_RSVD7);
  assign start     = accept && in_idle && ((op == OP_STEP) || (op == OP_RUN));
  assign bp_wr_ok  = accept && in_idle;
  assign idx_ok    = (int'(cmd.cmd_idx) < BP_NUM);
  assign step_load = (cmd.cmd_arg[15:0] == 16'd0) ? 16'd1 : cmd.cmd_arg[15:0];

  // Rejected: reserved ops anywhere, and anything but HALT while a
  // STEP/RUN is in flight.
  assign err_nxt   = accept && (is_rsvd || (!in_idle && !is_halt));

  // Breakpoint match. Scanning from the top down lets the lowest matching
  // slot win when several enabled entries hold the same address.
  always_comb begin
    bp_hit = 1'b0;
    bp_idx = '0;
    for (int i = BP_NUM - 1; i >= 0; i--) begin
      if (bp_en[i] && (bp_addr[i] == pc)) begin
        bp_hit = 1'b1;
        bp_idx = IDX_W'(i);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and stop decision. CHK is the cycle after the low phase, so
  // pc has settled from the last cpu_clk rising edge. Stop priority is
  // breakpoint, then pending halt, then step exhaustion.
  always_comb begin
    next_state = state;
    stop       = 1'b0;
    cause_nxt  = cause_q;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = P_HI;
        end
      end
      P_HI: begin
        next_state = P_LO;
      end
      P_LO: begin
        next_state = CHK;
      end
      CHK: begin
        if (bp_hit) begin
          stop      = 1'b1;
          cause_nxt = CAUSE_BP;
        end else if (halt_pend) begin
          stop      = 1'b1;
          cause_nxt = CAUSE_HALT;
        end else if (step_mode && (step_cnt == 16'd1)) begin
          stop      = 1'b1;
          cause_nxt = CAUSE_STEP;
        end
        next_state = stop ? IDLE : P_HI;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Registered outputs and run bookkeeping. cpu_clk and running follow the
  // next state so they line up with the state they describe; done and
  // cmd_err pulse one cycle after their cause.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_clk    <= 1'b0;
      running    <= 1'b0;
      done       <= 1'b0;
      cmd_err_q  <= 1'b0;
      cause_q    <= CAUSE_STEP;
      bp_hit_idx <= '0;
      halt_pend  <= 1'b0;
      step_mode  <= 1'b0;
      step_cnt   <= 16'd0;
    end else begin
      cpu_clk   <= (next_state == P_HI);
      running   <= (next_state != IDLE);
      done      <= stop;
      cmd_err_q <= err_nxt;

      if (start) begin
        step_mode <= (op == OP_STEP);
        step_cnt  <= step_load;
      end else if ((state == CHK) && !stop && step_mode) begin
        step_cnt <= step_cnt - 16'd1;
      end

      // A halt arriving in the same CHK that stops for another reason is
      // absorbed by that stop rather than left pending for the next run.
      if (start || stop) begin
        halt_pend <= 1'b0;
      end else if (accept && is_halt && !in_idle) begin
        halt_pend <= 1'b1;
      end

      if (stop) begin
        cause_q <= cause_nxt;
        if (cause_nxt == CAUSE_BP) begin
          bp_hit_idx <= bp_idx;
        end
      end
    end
  end

  assign stop_cause = cause_q;

  // Breakpoint enables; only reachable from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      bp_en <= '0;
    end else if (bp_wr_ok) begin
      case (op)
        OP_SETBP: if (idx_ok) bp_en[cmd.cmd_idx] <= 1'b1;
        OP_CLRBP: if (idx_ok) bp_en[cmd.cmd_idx] <= 1'b0;
        OP_CLRALL: bp_en <= '0;
        default: ;
      endcase
    end
  end

  // Breakpoint addresses carry no reset; an entry is meaningless until its
  // enable is set, which happens together with the address write.
  always_ff @(posedge clk) begin
    if (bp_wr_ok && (op == OP_SETBP) && idx_ok) begin
      bp_addr[cmd.cmd_idx] <= cmd.cmd_arg;
    end
  end

`ifdef DBG_CYC_CNT_EN
  logic [31:0] cyc_cnt_q;

  // Pulse counter: cleared at run start, one count per high phase, holds
  // across the stop so the front end can read it with the dump.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt_q <= 32'd0;
    end else if (start) begin
      cyc_cnt_q <= 32'd0;
    end else if (state == P_HI) begin
      cyc_cnt_q <= cyc_cnt_q + 32'd1;
    end
  end

  assign cyc_cnt = cyc_cnt_q;
`else
  assign cyc_cnt = 32'd0;
`endif

endmodule

// File: doc/dbg_run_ctrl.md
# dbg_run_ctrl

Run-control sequencer for the debug unit's CPU clock. It takes one-shot commands from the debug command parser: single/multi-step, free-run, halt, and breakpoint set/clear. It generates the gated `cpu_clk` pulse train for the pipelined CPU and compares the IF-stage PC against a small breakpoint file after every pulse. It replaces the ad-hoc T/G/H clock gating in the debug front end and gives that front end a single stop event to trigger the state dump.

## Interface
- `BP_NUM`, 4, number of breakpoint slots; power of two, 1..16.
- `IDX_W`, 2, slot index width; must equal clog2(`BP_NUM`), minimum 1.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_vld`  in  1  command valid.
- `cmd_rdy`  out  1  command ready; a command is accepted on a cycle with `cmd_vld & cmd_rdy`.
- `cmd_op`  in  3  0=STEP, 1=RUN, 2=HALT, 3=SETBP, 4=CLRBP, 5=CLRALL, 6-7 reserved.
- `cmd_idx`  in  IDX_W  breakpoint slot for SETBP/CLRBP.
- `cmd_arg`  in  32  breakpoint address (SETBP), or step count (STEP, low 16 bits; 0 is treated as 1).
- `pc`  in  32  CPU IF-stage PC, updated by `cpu_clk` rising edge.
- `cpu_clk`  out  1  gated CPU clock; registered.
- `running`  out  1  high while a STEP or RUN is in progress.
- `done`  out  1  one-cycle stop event.
- `stop_cause`  out  2  0=step count exhausted, 1=breakpoint, 2=halt; held until the next STEP/RUN.
- `bp_hit_idx`  out  IDX_W  matching slot; valid when `stop_cause`=1.
- `cmd_err`  out  1  one-cycle pulse when a command is rejected.
- `cyc_cnt`  out  32  CPU pulses issued (see Configuration).

## Operation
- Breakpoint file: `BP_NUM` entries of {en, addr[31:0]}.
  - SETBP writes addr and sets en.
  - CLRBP clears en of `cmd_idx`.
  - CLRALL clears all en.
  - These apply on the accept edge, generate no pulse and are legal only in IDLE.
- FSM states:
  - IDLE
  - P_HI: `cpu_clk`=1
  - P_LO: `cpu_clk`=0
  - CHK: `cpu_clk`=0, `pc` settled, compare
- Transitions:
  - IDLE -> P_HI on accepted STEP/RUN. The step counter loads max(arg[15:0],1); `running`=1.
  - P_HI -> P_LO -> CHK unconditionally.
  - CHK: stop if any enabled addr == `pc`. Otherwise stop if a halt is pending. Otherwise, for STEP, decrement the counter and stop at 0. Otherwise go to P_HI.
  - Stop: next state IDLE; `done`=1 in the first IDLE cycle; `running`=0 in that same cycle.
- Breakpoints are checked only after a pulse. Starting a RUN with `pc` sitting on an enabled breakpoint therefore always advances at least one instruction.
- Multiple simultaneous matches: lowest index is reported.
- Priority in CHK: breakpoint > halt > step exhaustion.
- `cmd_rdy` is 1 in every state.
  - HALT accepted while running sets a pending flag; the CPU stops at the next CHK.
  - HALT in IDLE: no-op; no `done`, no `cmd_err`.
  - Any non-HALT op accepted while running is dropped and raises `cmd_err`.
  - A reserved op raises `cmd_err` in any state.
- Step count arithmetic is 16-bit unsigned; no wrap occurs because the count is at least 1 and stops at 0.

## Timing
- Reset values: `cpu_clk`=0, `running`=0, `done`=0, `cmd_err`=0, `stop_cause`=0, `bp_hit_idx`=0, `cyc_cnt`=0, all en=0, halt pending=0, state IDLE.
- Reset asserted mid-pulse: `cpu_clk` is 0 from the following edge and no `done` is generated.
- Each CPU pulse is exactly 3 `clk` cycles: 1 high, 2 low.
- STEP N with no breakpoint hit:
  - accept at edge 0; `cpu_clk` high in cycles 1, 4, …, 3N−2
  - `done` in cycle 3N+1
- Latency, HALT accept to `done`: at most 4 cycles.
- `cmd_err` and `done` are registered and pulse in the cycle after the causing event.

## Configuration
- `DBG_CYC_CNT_EN` defined:
  - `cyc_cnt` clears on each accepted STEP/RUN.
  - It increments on each P_HI cycle, with 32-bit wrap.
  - It holds after stop.
- `DBG_CYC_CNT_EN` undefined: `cyc_cnt` is tied to 0 and the counter logic is absent.

## Test plan
- Reset, then STEP arg=0 with `pc` incrementing by 4 per pulse -> exactly one `cpu_clk` pulse; `done` 3 cycles after the pulse rises; `stop_cause`=0; `cyc_cnt`=1.
- SETBP idx=1 addr=0x0000_0010; RUN from `pc`=0x0 -> 4 pulses; `stop_cause`=1; `bp_hit_idx`=1; `pc`=0x10 at `done`.
- RUN with `pc` on an enabled breakpoint at 0x10; bench advances `pc` to 0x14 -> at least one pulse issued; no stop until 0x10 recurs.
- RUN, no breakpoints; HALT accepted in the P_HI of the 5th pulse -> stops after that pulse; `stop_cause`=2; `cyc_cnt`=5; HALT-to-`done` ≤ 4 cycles.
- While running: SETBP -> `cmd_err` pulse, breakpoint not written. In IDLE: op=7 -> `cmd_err` pulse. HALT in IDLE -> no `done`.
- STEP arg=100, assert `rst` during the 3rd pulse's P_HI -> `cpu_clk`=0 next cycle; `running`=0; no `done`; all breakpoints disabled.
